// File: rtl/parsing_top.sv
// parsing_top: 16-bank word store streamed out as paired low/high 8-lane beats.
// Define PARSING_ZERO_PAD_EN to frame each run with one all-zero step before and after.
module parsing_top #(
  parameter int N_WORDS = 128
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         iStart,
  input  logic [15:0]  i_ena,
  input  logic [8:0]   i_addra,
  input  logic [15:0]  i_wea,
  input  logic [127:0] i_dia,
  output logic [7:0]   oDin0_0, oDin0_1, oDin0_2, oDin0_3, oDin0_4, oDin0_5, oDin0_6, oDin0_7,
  output logic [7:0]   oDin0_8, oDin0_9, oDin0_10, oDin0_11, oDin0_12, oDin0_13, oDin0_14, oDin0_15,
  output logic [7:0]   oDin1_0, oDin1_1, oDin1_2, oDin1_3, oDin1_4, oDin1_5, oDin1_6, oDin1_7,
  output logic [7:0]   oDin1_8, oDin1_9, oDin1_10, oDin1_11, oDin1_12, oDin1_13, oDin1_14, oDin1_15,
  output logic [7:0]   oDin2_0, oDin2_1, oDin2_2, oDin2_3, oDin2_4, oDin2_5, oDin2_6, oDin2_7,
  output logic [7:0]   oDin2_8, oDin2_9, oDin2_10, oDin2_11, oDin2_12, oDin2_13, oDin2_14, oDin2_15,
  output logic [7:0]   oDin3_0, oDin3_1, oDin3_2, oDin3_3, oDin3_4, oDin3_5, oDin3_6, oDin3_7,
  output logic [7:0]   oDin3_8, oDin3_9, oDin3_10, oDin3_11, oDin3_12, oDin3_13, oDin3_14, oDin3_15,
  output logic [7:0]   oDin4_0, oDin4_1, oDin4_2, oDin4_3, oDin4_4, oDin4_5, oDin4_6, oDin4_7,
  output logic [7:0]   oDin4_8, oDin4_9, oDin4_10, oDin4_11, oDin4_12, oDin4_13, oDin4_14, oDin4_15,
  output logic [7:0]   oDin5_0, oDin5_1, oDin5_2, oDin5_3, oDin5_4, oDin5_5, oDin5_6, oDin5_7,
  output logic [7:0]   oDin5_8, oDin5_9, oDin5_10, oDin5_11, oDin5_12, oDin5_13, oDin5_14, oDin5_15,
  output logic [7:0]   oDin6_0, oDin6_1, oDin6_2, oDin6_3, oDin6_4, oDin6_5, oDin6_6, oDin6_7,
  output logic [7:0]   oDin6_8, oDin6_9, oDin6_10, oDin6_11, oDin6_12, oDin6_13, oDin6_14, oDin6_15,
  output logic [7:0]   oDin7_0, oDin7_1, oDin7_2, oDin7_3, oDin7_4, oDin7_5, oDin7_6, oDin7_7,
  output logic [7:0]   oDin7_8, oDin7_9, oDin7_10, oDin7_11, oDin7_12, oDin7_13, oDin7_14, oDin7_15,
  output logic         oMac_vld
);

  typedef enum logic [2:0] {IDLE, PAD_PRE, RUN, PAD_POST, DONE} state_t;
  localparam logic [8:0] LAST_ADDR = 9'(N_WORDS - 1);

  state_t       state_q, state_d;
  logic [8:0]   addr_q, addr_d;
  logic         beat_q, beat_d;
  logic         start_q, start_d, start_prev_q;
  logic         start_edge;

  logic [127:0] mem [16][512];
  logic [127:0] rd_p0_q [16];
  logic         vld_p0_q, vld_p0_d;
  logic         hi_p0_q, hi_p0_d;
  logic         zero_p0_q, zero_p0_d;
  logic [127:0] lane_p1_q [8];
  logic [127:0] lane_p1_d [8];
  logic         vld_p1_q;

  assign start_d    = iStart;
  assign start_edge = start_q & ~start_prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beat_q       <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      start_q      <= start_d;
      start_prev_q <= start_q;
    end
  end

  // beat_q selects low (banks 0..7) or high (banks 8..15) half of the current step
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        beat_d = 1'b0;
        if (start_edge) begin
`ifdef PARSING_ZERO_PAD_EN
          state_d = PAD_PRE;
`else
          state_d = RUN;
`endif
        end
      end
      PAD_PRE: begin
        beat_d = ~beat_q;
        if (beat_q) state_d = RUN;
      end
      RUN: begin
        beat_d = ~beat_q;
        if (beat_q) begin
          if (addr_q == LAST_ADDR) begin
`ifdef PARSING_ZERO_PAD_EN
            state_d = PAD_POST;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d = addr_q + 9'd1;
          end
        end
      end
      PAD_POST: begin
        beat_d = ~beat_q;
        if (beat_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_p0_d  = 1'b0;
    zero_p0_d = 1'b0;
    hi_p0_d   = beat_q;
    case (state_q)
      PAD_PRE, PAD_POST: begin
        vld_p0_d  = 1'b1;
        zero_p0_d = 1'b1;
      end
      RUN:     vld_p0_d = 1'b1;
      default: vld_p0_d = 1'b0;
    endcase
  end

  // ---- stage p0: bank read (read-first), beat tag aligned with read data ----
  always_ff @(posedge clk) begin
    for (int b = 0; b < 16; b++) begin
      if (i_ena[b] && i_wea[b]) mem[b][i_addra] <= i_dia;
      rd_p0_q[b] <= mem[b][addr_q];
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      lane_p1_d[r] = '0;
      if (vld_p0_q && !zero_p0_q) lane_p1_d[r] = hi_p0_q ? rd_p0_q[r + 8] : rd_p0_q[r];
    end
  end

  // ---- stage p1: registered outputs, forced to zero whenever not valid ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0_q  <= 1'b0;
      hi_p0_q   <= 1'b0;
      zero_p0_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      for (int r = 0; r < 8; r++) lane_p1_q[r] <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      hi_p0_q   <= hi_p0_d;
      zero_p0_q <= zero_p0_d;
      vld_p1_q  <= vld_p0_q;
      for (int r = 0; r < 8; r++) lane_p1_q[r] <= lane_p1_d[r];
    end
  end

  assign oMac_vld = vld_p1_q;
  assign {oDin0_15, oDin0_14, oDin0_13, oDin0_12, oDin0_11, oDin0_10, oDin0_9, oDin0_8,
          oDin0_7, oDin0_6, oDin0_5, oDin0_4, oDin0_3, oDin0_2, oDin0_1, oDin0_0} = lane_p1_q[0];
  assign {oDin1_15, oDin1_14, oDin1_13, oDin1_12, oDin1_11, oDin1_10, oDin1_9, oDin1_8,
          oDin1_7, oDin1_6, oDin1_5, oDin1_4, oDin1_3, oDin1_2, oDin1_1, oDin1_0} = lane_p1_q[1];
  assign {oDin2_15, oDin2_14, oDin2_13, oDin2_12, oDin2_11, oDin2_10, oDin2_9, oDin2_8,
          oDin2_7, oDin2_6, oDin2_5, oDin2_4, oDin2_3, oDin2_2, oDin2_1, oDin2_0} = lane_p1_q[2];
  assign {oDin3_15, oDin3_14, oDin3_13, oDin3_12, oDin3_11, oDin3_10, oDin3_9, oDin3_8,
          oDin3_7, oDin3_6, oDin3_5, oDin3_4, oDin3_3, oDin3_2, oDin3_1, oDin3_0} = lane_p1_q[3];
  assign {oDin4_15, oDin4_14, oDin4_13, oDin4_12, oDin4_11, oDin4_10, oDin4_9, oDin4_8,
          oDin4_7, oDin4_6, oDin4_5, oDin4_4, oDin4_3, oDin4_2, oDin4_1, oDin4_0} = lane_p1_q[4];
  assign {oDin5_15, oDin5_14, oDin5_13, oDin5_12, oDin5_11, oDin5_10, oDin5_9, oDin5_8,
          oDin5_7, oDin5_6, oDin5_5, oDin5_4, oDin5_3, oDin5_2, oDin5_1, oDin5_0} = lane_p1_q[5];
  assign {oDin6_15, oDin6_14, oDin6_13, oDin6_12, oDin6_11, oDin6_10, oDin6_9, oDin6_8,
          oDin6_7, oDin6_6, oDin6_5, oDin6_4, oDin6_3, oDin6_2, oDin6_1, oDin6_0} = lane_p1_q[6];
  assign {oDin7_15, oDin7_14, oDin7_13, oDin7_12, oDin7_11, oDin7_10, oDin7_9, oDin7_8,
          oDin7_7, oDin7_6, oDin7_5, oDin7_4, oDin7_3, oDin7_2, oDin7_1, oDin7_0} = lane_p1_q[7];

endmodule

// File: tb/tb_parsing_top.sv
// Scoreboard bench for parsing_top: beats expected from a bank model are queued at run start
// and compared lane by lane as oMac_vld beats arrive.
module tb_parsing_top;

  localparam int N = 128;
`ifdef PARSING_ZERO_PAD_EN
  localparam int PAD     = 1;
`else
  localparam int PAD     = 0;
`endif
  localparam int EXP_LEN = 2 * (N + 2 * PAD);
  localparam int FIRST   = 2 * PAD;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         iStart = 1'b0;
  logic [15:0]  i_ena = '0;
  logic [8:0]   i_addra = '0;
  logic [15:0]  i_wea = '0;
  logic [127:0] i_dia = '0;
  logic [7:0]   ob [8][16];
  logic         vld;

  logic [127:0] mdl [16][512];
  logic [1023:0] sb [$];
  int total = 0;
  int bad = 0;
  int cur_len = 0;
  int last_len = 0;
  int runs_seen = 0;
  int beat_cnt = 0;

  always #5 clk = ~clk;

  parsing_top dut (
    .clk(clk), .rstn(rstn), .iStart(iStart), .i_ena(i_ena), .i_addra(i_addra), .i_wea(i_wea), .i_dia(i_dia),
    .oDin0_0(ob[0][0]), .oDin0_1(ob[0][1]), .oDin0_2(ob[0][2]), .oDin0_3(ob[0][3]), .oDin0_4(ob[0][4]), .oDin0_5(ob[0][5]), .oDin0_6(ob[0][6]), .oDin0_7(ob[0][7]),
    .oDin0_8(ob[0][8]), .oDin0_9(ob[0][9]), .oDin0_10(ob[0][10]), .oDin0_11(ob[0][11]), .oDin0_12(ob[0][12]), .oDin0_13(ob[0][13]), .oDin0_14(ob[0][14]), .oDin0_15(ob[0][15]),
    .oDin1_0(ob[1][0]), .oDin1_1(ob[1][1]), .oDin1_2(ob[1][2]), .oDin1_3(ob[1][3]), .oDin1_4(ob[1][4]), .oDin1_5(ob[1][5]), .oDin1_6(ob[1][6]), .oDin1_7(ob[1][7]),
    .oDin1_8(ob[1][8]), .oDin1_9(ob[1][9]), .oDin1_10(ob[1][10]), .oDin1_11(ob[1][11]), .oDin1_12(ob[1][12]), .oDin1_13(ob[1][13]), .oDin1_14(ob[1][14]), .oDin1_15(ob[1][15]),
    .oDin2_0(ob[2][0]), .oDin2_1(ob[2][1]), .oDin2_2(ob[2][2]), .oDin2_3(ob[2][3]), .oDin2_4(ob[2][4]), .oDin2_5(ob[2][5]), .oDin2_6(ob[2][6]), .oDin2_7(ob[2][7]),
    .oDin2_8(ob[2][8]), .oDin2_9(ob[2][9]), .oDin2_10(ob[2][10]), .oDin2_11(ob[2][11]), .oDin2_12(ob[2][12]), .oDin2_13(ob[2][13]), .oDin2_14(ob[2][14]), .oDin2_15(ob[2][15]),
    .oDin3_0(ob[3][0]), .oDin3_1(ob[3][1]), .oDin3_2(ob[3][2]), .oDin3_3(ob[3][3]), .oDin3_4(ob[3][4]), .oDin3_5(ob[3][5]), .oDin3_6(ob[3][6]), .oDin3_7(ob[3][7]),
    .oDin3_8(ob[3][8]), .oDin3_9(ob[3][9]), .oDin3_10(ob[3][10]), .oDin3_11(ob[3][11]), .oDin3_12(ob[3][12]), .oDin3_13(ob[3][13]), .oDin3_14(ob[3][14]), .oDin3_15(ob[3][15]),
    .oDin4_0(ob[4][0]), .oDin4_1(ob[4][1]), .oDin4_2(ob[4][2]), .oDin4_3(ob[4][3]), .oDin4_4(ob[4][4]), .oDin4_5(ob[4][5]), .oDin4_6(ob[4][6]), .oDin4_7(ob[4][7]),
    .oDin4_8(ob[4][8]), .oDin4_9(ob[4][9]), .oDin4_10(ob[4][10]), .oDin4_11(ob[4][11]), .oDin4_12(ob[4][12]), .oDin4_13(ob[4][13]), .oDin4_14(ob[4][14]), .oDin4_15(ob[4][15]),
    .oDin5_0(ob[5][0]), .oDin5_1(ob[5][1]), .oDin5_2(ob[5][2]), .oDin5_3(ob[5][3]), .oDin5_4(ob[5][4]), .oDin5_5(ob[5][5]), .oDin5_6(ob[5][6]), .oDin5_7(ob[5][7]),
    .oDin5_8(ob[5][8]), .oDin5_9(ob[5][9]), .oDin5_10(ob[5][10]), .oDin5_11(ob[5][11]), .oDin5_12(ob[5][12]), .oDin5_13(ob[5][13]), .oDin5_14(ob[5][14]), .oDin5_15(ob[5][15]),
    .oDin6_0(ob[6][0]), .oDin6_1(ob[6][1]), .oDin6_2(ob[6][2]), .oDin6_3(ob[6][3]), .oDin6_4(ob[6][4]), .oDin6_5(ob[6][5]), .oDin6_6(ob[6][6]), .oDin6_7(ob[6][7]),
    .oDin6_8(ob[6][8]), .oDin6_9(ob[6][9]), .oDin6_10(ob[6][10]), .oDin6_11(ob[6][11]), .oDin6_12(ob[6][12]), .oDin6_13(ob[6][13]), .oDin6_14(ob[6][14]), .oDin6_15(ob[6][15]),
    .oDin7_0(ob[7][0]), .oDin7_1(ob[7][1]), .oDin7_2(ob[7][2]), .oDin7_3(ob[7][3]), .oDin7_4(ob[7][4]), .oDin7_5(ob[7][5]), .oDin7_6(ob[7][6]), .oDin7_7(ob[7][7]),
    .oDin7_8(ob[7][8]), .oDin7_9(ob[7][9]), .oDin7_10(ob[7][10]), .oDin7_11(ob[7][11]), .oDin7_12(ob[7][12]), .oDin7_13(ob[7][13]), .oDin7_14(ob[7][14]), .oDin7_15(ob[7][15]),
    .oMac_vld(vld)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lane_word(input int r);
    logic [127:0] w;
    for (int c = 0; c < 16; c++) w[8*c +: 8] = ob[r][c];
    return w;
  endfunction

  function automatic logic [127:0] all_or();
    logic [127:0] acc = '0;
    for (int r = 0; r < 8; r++) acc |= lane_word(r);
    return acc;
  endfunction

  function automatic logic [127:0] pat(input int b);
    logic [127:0] w;
    for (int c = 0; c < 16; c++) w[8*c +: 8] = 8'((c << 4) | b);
    return w;
  endfunction

  task automatic push_run();
    logic [1023:0] lo, hi;
    if (PAD != 0) begin
      sb.push_back('0);
      sb.push_back('0);
    end
    for (int a = 0; a < N; a++) begin
      for (int r = 0; r < 8; r++) begin
        lo[128*r +: 128] = mdl[r][a];
        hi[128*r +: 128] = mdl[r+8][a];
      end
      sb.push_back(lo);
      sb.push_back(hi);
    end
    if (PAD != 0) begin
      sb.push_back('0);
      sb.push_back('0);
    end
  endtask

  // Monitor: pops one expected beat per valid cycle; idle cycles must be all-zero
  always @(negedge clk) begin
    logic [1023:0] e;
    if (vld === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("extra_beat", 128'(cur_len), 128'(-1));
      end else begin
        e = sb.pop_front();
        for (int r = 0; r < 8; r++)
          check_val($sformatf("beat%0d_lane%0d", cur_len, r), lane_word(r), e[128*r +: 128]);
      end
      if (cur_len == FIRST) begin
        check_val("lo_d0_0", 128'(ob[0][0]), 128'h00);
        check_val("lo_d0_1", 128'(ob[0][1]), 128'h10);
        check_val("lo_d7_15", 128'(ob[7][15]), 128'hF7);
      end
      if (cur_len == FIRST + 1) begin
        check_val("hi_d0_0", 128'(ob[0][0]), 128'h08);
        check_val("hi_d7_15", 128'(ob[7][15]), 128'hFF);
      end
      cur_len++;
      beat_cnt++;
    end else begin
      if (cur_len != 0) begin
        last_len = cur_len;
        runs_seen++;
        cur_len = 0;
      end
      check_val("idle_zero", all_or(), '0);
    end
  end

  task automatic wr(input logic [15:0] ena, input logic [15:0] wea, input logic [8:0] a, input logic [127:0] d);
    i_ena = ena; i_wea = wea; i_addra = a; i_dia = d;
    @(posedge clk); #1;
    i_ena = '0; i_wea = '0;
  endtask

  task automatic do_run(input bit write_ahead);
    int n0;
    n0 = runs_seen;
    push_run();
    iStart = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("lat_e%0d", k), 128'(vld), 128'(k == 3));
    end
    if (write_ahead) wr(16'h0008, 16'h0008, 9'd120, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    for (int k = 0; k < 2000 && runs_seen == n0; k++) @(posedge clk);
    #1;
    check_val("run_done", 128'(runs_seen), 128'(n0 + 1));
    check_val("run_len", 128'(last_len), 128'(EXP_LEN));
    check_val("sb_empty", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vld", 128'(vld), 128'd0);
    check_val("rst_out", all_or(), '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int b = 0; b < 16; b++)
      for (int a = 0; a < N; a++) begin
        mdl[b][a] = pat(b);
        wr(16'(1 << b), 16'(1 << b), 9'(a), pat(b));
      end

    // Gated writes: enable without write-enable and vice versa must not land
    wr(16'h0001, 16'h0000, 9'd5, {16{8'hAA}});
    wr(16'h0000, 16'h0002, 9'd6, {16{8'h55}});

    // Run 1 with a write ahead of the read pointer; that value must stream in this run
    mdl[3][120] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    do_run(1'b1);

    // iStart stays high: no restart
    b0 = beat_cnt;
    repeat (40) @(posedge clk);
    #1;
    check_val("no_restart", 128'(beat_cnt - b0), 128'd0);

    iStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_run(1'b0);

    // Run 3 aborted by reset at beat 50
    iStart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_run();
    b0 = beat_cnt;
    iStart = 1'b1;
    for (int k = 0; k < 500 && beat_cnt < b0 + 50; k++) @(posedge clk);
    #2;
    check_val("beat50_reached", 128'(beat_cnt >= b0 + 50), 128'd1);
    rstn = 1'b0;
    #1;
    check_val("abort_vld", 128'(vld), 128'd0);
    check_val("abort_out", all_or(), '0);
    sb.delete();
    iStart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    b0 = beat_cnt;
    repeat (30) @(posedge clk);
    #1;
    check_val("no_beats_after_rst", 128'(beat_cnt - b0), 128'd0);

    // Contents survive reset and a fresh edge restarts cleanly
    do_run(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parsing_top.md
PARSING_TOP -- requirements
Module: parsing_top

Interface
REQ-001 Parameter N_WORDS, default 128: number of words per bank streamed per run, legal range 1..512.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 iStart  input  1  run request; a run starts on a 0->1 transition.
REQ-005 i_ena  input  16  per-bank write-port enable, bit b selects bank b.
REQ-006 i_addra  input  9  write address, common to all banks.
REQ-007 i_wea  input  16  per-bank write enable, whole 128-bit word.
REQ-008 i_dia  input  128  write data; byte c = bits [8c+7:8c].
REQ-009 oDinR_C  output  8  lane R (0..7), byte C (0..15) of the current beat; 128 ports total.
REQ-010 oMac_vld  output  1  high when the oDin* ports carry a valid beat.

Function
REQ-011 Storage: 16 banks, each 512 x 128 bits; bank b is written at i_addra with i_dia when i_ena[b] and i_wea[b] are both 1; several banks may be written in the same cycle.
REQ-012 Read port: internal, synchronous, 1-cycle latency; a same-address read and write in one cycle returns old data (read-first).
REQ-013 FSM states: IDLE, PAD_PRE, RUN, PAD_POST, DONE; the state is IDLE after reset.
REQ-014 iStart is registered and edge-detected; a rising edge in IDLE moves the FSM to PAD_PRE; edges seen in other states are ignored; holding iStart high never restarts a run.
REQ-015 Each output step is two consecutive beats: the low beat (banks 0..7) then the high beat (banks 8..15).
REQ-016 Beat mapping: oDinR_C = byte C of bank R in the low beat and byte C of bank R+8 in the high beat, taken from the word at the step's read address.
REQ-017 PAD_PRE emits one zero step (2 beats, all bytes 0x00); RUN emits N_WORDS steps reading addresses 0..N_WORDS-1 in increasing order; PAD_POST emits one zero step; DONE lasts 1 cycle, then the FSM returns to IDLE.
REQ-018 All beats of a run are contiguous: oMac_vld is high for exactly 2*(N_WORDS+2) consecutive cycles, 260 by default.
REQ-019 The first oMac_vld=1 appears on the 3rd rising edge after the edge that samples the iStart rising edge; outputs are registered.
REQ-020 When oMac_vld=0, all oDin* ports are 0x00.
REQ-021 Writes remain enabled during a run; data written ahead of the read pointer is streamed in that same run.
REQ-022 Read addresses are 9 bits; the address counter stops at N_WORDS-1 and does not wrap.
REQ-023 A new run requires iStart to go low and then high again after the FSM is back in IDLE.

Reset
REQ-024 rstn=0 asynchronously forces: FSM to IDLE, address and beat counters to 0, the registered iStart to 0, oMac_vld to 0 and all oDin* ports to 0x00.
REQ-025 Reset does not clear bank contents.
REQ-026 Reset asserted mid-run aborts the run immediately; no further beats appear after rstn is released.

Configuration
REQ-027 Macro PARSING_ZERO_PAD_EN defined: PAD_PRE and PAD_POST are present, so a run is 2*(N_WORDS+2) beats.
REQ-028 Macro PARSING_ZERO_PAD_EN undefined: the FSM goes IDLE -> RUN -> DONE, a run is 2*N_WORDS beats, and the first data beat appears on the 3rd edge after the start edge.

Verification
REQ-029 Load: fill bank b, addresses 0..127, with word byte c = (c<<4)|b (bank 0 = 0xF0E0...1000); pulse iStart -> 2 zero beats, then low beats with oDin0_0=0x00, oDin0_1=0x10, oDin7_15=0xF7, and high beats with oDin0_0=0x08, oDin7_15=0xFF.
REQ-030 Count: oMac_vld high for exactly 260 consecutive cycles (256 without PARSING_ZERO_PAD_EN); the last 2 beats are all-zero.
REQ-031 Write gating: i_ena=0x0001 with i_wea=0x0000 at address 5 -> bank 0 address 5 is unchanged on readout.
REQ-032 Hold iStart high after DONE -> no second run; drop and re-raise iStart -> an identical second run.
REQ-033 Assert rstn=0 at beat 50 -> oMac_vld and all outputs 0 within the same cycle; after release, no beats appear until a new iStart edge.
